hardfloat_result_checker: RTL and testbench
===========================================

# hardfloat_result_checker

Synthesizable, parametrised result checker for hardfloat test benches. It buffers per-test expected values (IEEE, recoded, exception flags) for LANES parallel lanes and pairs them in order with the results of a DUT that has arbitrary latency. It counts tests and mismatching beats, emits progress pulses and per-failure records, and stops the run at a configurable error limit. It sits between the vector source and a pipelined hardfloat DUT, replacing per-cycle behavioural comparison with a handshaked, latency-tolerant checker.

## Interface
- LANES, 1, number of parallel result lanes compared per beat
- IEEE_W, 64, IEEE result width per lane
- REC_W, 65, recoded result width per lane
- EXC_W, 5, exception flag width per lane
- DEPTH, 16, expected-value FIFO depth (power of two, ≥2)
- ERROR_LIMIT, 20, mismatching beats before abort
- REPORT_INTERVAL, 10000, tests between progress pulses
- CNT_W, 32, counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- exp_valid  in  1  expected beat offered
- exp_ready  out  1  FIFO can accept
- exp_last  in  1  final expected beat of the run
- exp_ieee  in  LANES*IEEE_W  expected IEEE results, lane 0 in LSBs
- exp_recoded  in  LANES*REC_W  expected recoded results
- exp_exception  in  LANES*EXC_W  expected flags
- act_valid  in  1  DUT result beat (no backpressure; the checker always accepts)
- act_ieee  in  LANES*IEEE_W  actual IEEE results
- act_recoded  in  LANES*REC_W  actual recoded results
- act_exception  in  LANES*EXC_W  actual flags
- test_count  out  CNT_W  beats checked
- error_count  out  CNT_W  mismatching beats, including orphans
- fail_valid  out  1  one-cycle failure record strobe
- fail_lane_mask  out  LANES  lanes that mismatched
- fail_index  out  CNT_W  test_count value of the failing beat
- orphan  out  1  sticky; result arrived with FIFO empty
- progress  out  1  one-cycle pulse
- done  out  1  sticky; all expected beats checked cleanly to end
- abort  out  1  sticky; ERROR_LIMIT reached

## Operation
- States: RUN, DRAIN, DONE, ABORT. Reset state is RUN.
- RUN:
  - Push on exp_valid&&exp_ready.
  - Pushing with exp_last moves to DRAIN; no further pushes are accepted.
- DRAIN: exp_ready=0. The FIFO becoming empty after a pop moves to DONE.
- Pop on act_valid while the FIFO is non-empty.
- Lane comparison: a lane fails if its IEEE or exception field differs. The recoded field also counts when compiled in (see Configuration).
- Beat with any failing lane:
  - error_count increments by 1.
  - fail_valid is asserted with the lane mask and fail_index equal to the pre-increment test_count.
- test_count increments by 1 on every popped beat.
- act_valid with the FIFO empty:
  - Counts as an orphan: error_count increments and orphan sets.
  - test_count does not increment, and fail_valid is not asserted.
- error_count reaching ERROR_LIMIT moves to ABORT from any state:
  - ABORT: exp_ready=0, act ignored, counters frozen.
  - ABORT has priority over DONE in the same cycle.
- progress pulses when the incremented test_count is a nonzero multiple of REPORT_INTERVAL.
- DONE and ABORT exit only via reset.

## Timing
- Reset values: all counters 0, FIFO empty, every flag/strobe 0, exp_ready=1.
- exp_ready = (state==RUN) && !full. It is based on occupancy only; a full FIFO with a simultaneous pop still gives ready=0.
- No bypass: a push and act_valid on an empty FIFO in the same cycle counts an orphan, and the pushed entry remains.
- Comparison uses the FIFO head combinationally. Counters, fail_*, progress and orphan are registered, visible 1 cycle after the act beat.
- done and abort assert in the cycle after the terminating beat.
- Asynchronous reset mid-run discards FIFO contents immediately.
- Counters saturate at all-ones.

## Configuration
- HARDFLOAT_CHECK_RECODED_EN defined: the recoded field participates in lane comparison, and the recoded portion of each FIFO entry is stored.
- Undefined: the recoded ports remain, inputs are ignored, and the FIFO omits recoded storage.

## Structure
- Package hardfloat_check_pkg:
  - state enum (RUN, DRAIN, DONE, ABORT)
  - default width constants (IEEE_W, REC_W, EXC_W)
  - function packing one lane's expected entry
- Sub-module hardfloat_check_fifo: parametrised width/DEPTH synchronous FIFO with full/empty and async active-low reset.

## Test plan
- LANES=2, 5 matching beats, DUT latency 3, last on beat 5:
  - test_count=5, error_count=0, done=1 one cycle after the 5th result.
- Beat 2 lane 1 IEEE mismatch (exp 0x3FF0000000000000, act 0x4000000000000000):
  - fail_valid with mask=2'b10, fail_index=2, error_count=1.
- ERROR_LIMIT=3, every beat mismatching:
  - abort after 3rd failing beat, exp_ready=0, later act beats leave counters at 3.
- act_valid with empty FIFO at reset+2:
  - orphan=1, error_count=1, test_count=0.
- DEPTH=4, source continuous, DUT stalled:
  - exp_ready falls after 4 pushes and rises the cycle after the first pop.
- REPORT_INTERVAL=4, 9 matching beats:
  - progress pulses exactly after tests 4 and 8.
  - With the macro defined, a recoded-only mismatch gives fail_valid; with it undefined, no failure.

Source files
------------

// File: rtl/hardfloat_check_pkg.sv
// Shared types and helpers for the hardfloat result checker.
// Each lane's expected entry holds {exception, ieee} at the default field widths.
package hardfloat_check_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   localparam int DEF_IEEE_W = 64;
   localparam int DEF_REC_W  = 65;
   localparam int DEF_EXC_W  = 5;
   localparam int ENTRY_W    = DEF_EXC_W + DEF_IEEE_W;

   // Narrower fields are zero-extended by the caller, so both sides compare alike
   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DEF_IEEE_W-1:0] ieee,
                                                     input logic [DEF_EXC_W-1:0]  exc);
      return {exc, ieee};
   endfunction

endpackage

// File: rtl/hardfloat_check_fifo.sv
// Synchronous FIFO for expected beats; DEPTH must be a power of two.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module hardfloat_check_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Read/write pointers; reset discards contents immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/hardfloat_result_checker.sv
// Latency-tolerant result checker pairing buffered expected beats with DUT results in order.
// Define HARDFLOAT_CHECK_RECODED_EN to store and compare the recoded field as well.
module hardfloat_result_checker
   import hardfloat_check_pkg::*;
#(
   parameter int LANES           = 1,
   parameter int IEEE_W          = DEF_IEEE_W,
   parameter int REC_W           = DEF_REC_W,
   parameter int EXC_W           = DEF_EXC_W,
   parameter int DEPTH           = 16,
   parameter int ERROR_LIMIT     = 20,
   parameter int REPORT_INTERVAL = 10000,
   parameter int CNT_W           = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   exp_valid,
   output logic                   exp_ready,
   input  logic                   exp_last,
   input  logic [LANES*IEEE_W-1:0] exp_ieee,
   input  logic [LANES*REC_W-1:0]  exp_recoded,
   input  logic [LANES*EXC_W-1:0]  exp_exception,
   input  logic                   act_valid,
   input  logic [LANES*IEEE_W-1:0] act_ieee,
   input  logic [LANES*REC_W-1:0]  act_recoded,
   input  logic [LANES*EXC_W-1:0]  act_exception,
   output logic [CNT_W-1:0]       test_count,
   output logic [CNT_W-1:0]       error_count,
   output logic                   fail_valid,
   output logic [LANES-1:0]       fail_lane_mask,
   output logic [CNT_W-1:0]       fail_index,
   output logic                   orphan,
   output logic                   progress,
   output logic                   done,
   output logic                   abort
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ERROR_LIMIT);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPORT_INTERVAL - 1);
   localparam logic [AW:0]      FIFO_ONE = {{AW{1'b0}}, 1'b1};

   state_t                   state;
   logic                     fifo_full, fifo_empty, push, pop;
   logic [AW:0]              fifo_count;
   logic [LANES*ENTRY_W-1:0] exp_pack, act_pack, head_pack;
   logic [LANES-1:0]         lane_fail;
   logic                     act_live, orphan_ev, beat_fail, err_inc;
   logic [CNT_W-1:0]         err_next, test_next, rep_cnt;

`ifdef HARDFLOAT_CHECK_RECODED_EN
   localparam int FIFO_W = LANES * (ENTRY_W + REC_W);
   logic [FIFO_W-1:0]        fifo_din, fifo_dout;
   logic [LANES*REC_W-1:0]   head_rec;
   assign fifo_din  = {exp_recoded, exp_pack};
   assign head_rec  = fifo_dout[FIFO_W-1 -: LANES*REC_W];
   assign head_pack = fifo_dout[LANES*ENTRY_W-1:0];
`else
   localparam int FIFO_W = LANES * ENTRY_W;
   logic [FIFO_W-1:0]        fifo_din, fifo_dout;
   logic                     unused_rec;
   assign unused_rec = ^{exp_recoded, act_recoded};
   assign fifo_din   = exp_pack;
   assign head_pack  = fifo_dout;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DEF_IEEE_W-1:0] e_ieee, a_ieee;
      logic [DEF_EXC_W-1:0]  e_exc, a_exc;
      // Zero-extend this lane's fields to the packed entry layout
      always_comb begin
         e_ieee = '0;
         a_ieee = '0;
         e_exc  = '0;
         a_exc  = '0;
         e_ieee[IEEE_W-1:0] = exp_ieee[l*IEEE_W +: IEEE_W];
         a_ieee[IEEE_W-1:0] = act_ieee[l*IEEE_W +: IEEE_W];
         e_exc[EXC_W-1:0]   = exp_exception[l*EXC_W +: EXC_W];
         a_exc[EXC_W-1:0]   = act_exception[l*EXC_W +: EXC_W];
      end
      assign exp_pack[l*ENTRY_W +: ENTRY_W] = pack_entry(e_ieee, e_exc);
      assign act_pack[l*ENTRY_W +: ENTRY_W] = pack_entry(a_ieee, a_exc);
`ifdef HARDFLOAT_CHECK_RECODED_EN
      assign lane_fail[l] = (head_pack[l*ENTRY_W +: ENTRY_W] != act_pack[l*ENTRY_W +: ENTRY_W]) ||
                            (head_rec[l*REC_W +: REC_W] != act_recoded[l*REC_W +: REC_W]);
`else
      assign lane_fail[l] = (head_pack[l*ENTRY_W +: ENTRY_W] != act_pack[l*ENTRY_W +: ENTRY_W]);
`endif
   end

   hardfloat_check_fifo #(.WIDTH(FIFO_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Ready follows occupancy only, so a full FIFO stays not-ready even while popping
   assign exp_ready = (state == ST_RUN) && !fifo_full;
   assign push      = exp_valid && exp_ready;
   assign act_live  = act_valid && (state != ST_ABORT);
   assign pop       = act_live && !fifo_empty;
   assign orphan_ev = act_live && fifo_empty;
   assign beat_fail = pop && (|lane_fail);
   assign err_inc   = beat_fail || orphan_ev;
   assign err_next  = (error_count == CNT_MAX) ? error_count : error_count + CNT_ONE;
   assign test_next = (test_count == CNT_MAX) ? test_count : test_count + CNT_ONE;
   assign done      = (state == ST_DONE);
   assign abort     = (state == ST_ABORT);

   // Run-control FSM with counters, failure record and progress strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_RUN;
         test_count     <= '0;
         error_count    <= '0;
         rep_cnt        <= '0;
         fail_valid     <= 1'b0;
         fail_lane_mask <= '0;
         fail_index     <= '0;
         orphan         <= 1'b0;
         progress       <= 1'b0;
      end else begin
         fail_valid <= beat_fail;
         progress   <= pop && (test_count != CNT_MAX) && (rep_cnt == REP_LAST);
         if (beat_fail) begin
            fail_lane_mask <= lane_fail;
            fail_index     <= test_count;
         end
         if (orphan_ev) orphan <= 1'b1;
         if (err_inc) error_count <= err_next;
         if (pop) begin
            test_count <= test_next;
            rep_cnt    <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + CNT_ONE;
         end
         if (err_inc && (err_next == LIMIT)) begin
            state <= ST_ABORT;
         end else begin
            case (state)
               ST_RUN:   if (push && exp_last) state <= ST_DRAIN;
               ST_DRAIN: if (pop && (fifo_count == FIFO_ONE)) state <= ST_DONE;
               ST_DONE:  state <= ST_DONE;
               ST_ABORT: state <= ST_ABORT;
               default:  state <= ST_RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hardfloat_result_checker.sv
// Directed bench for hardfloat_result_checker: LANES=2, DEPTH=4, ERROR_LIMIT=3, REPORT_INTERVAL=4.
// The recoded scenario expects a failure only when HARDFLOAT_CHECK_RECODED_EN is defined.
module tb_hardfloat_result_checker;
   localparam int LANES = 2;
   localparam int IW    = 64;
   localparam int RW    = 65;
   localparam int EW    = 5;
   localparam int CW    = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                exp_valid, exp_ready, exp_last;
   logic [LANES*IW-1:0] exp_ieee, act_ieee;
   logic [LANES*RW-1:0] exp_recoded, act_recoded;
   logic [LANES*EW-1:0] exp_exception, act_exception;
   logic                act_valid;
   logic [CW-1:0]       test_count, error_count, fail_index;
   logic                fail_valid, orphan, progress, done, abort;
   logic [LANES-1:0]    fail_lane_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hardfloat_result_checker #(
      .LANES(LANES), .IEEE_W(IW), .REC_W(RW), .EXC_W(EW), .DEPTH(4),
      .ERROR_LIMIT(3), .REPORT_INTERVAL(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_last(exp_last),
      .exp_ieee(exp_ieee), .exp_recoded(exp_recoded), .exp_exception(exp_exception),
      .act_valid(act_valid), .act_ieee(act_ieee), .act_recoded(act_recoded),
      .act_exception(act_exception),
      .test_count(test_count), .error_count(error_count),
      .fail_valid(fail_valid), .fail_lane_mask(fail_lane_mask), .fail_index(fail_index),
      .orphan(orphan), .progress(progress), .done(done), .abort(abort)
   );

   function automatic logic [IW-1:0] ieee_val(int k, int l);
      return {32'h3FF0_0000, 16'(k), 16'(l)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_exp(int k);
      for (int l = 0; l < LANES; l++) begin
         exp_ieee[l*IW +: IW]      = ieee_val(k, l);
         exp_recoded[l*RW +: RW]   = {1'b1, ieee_val(k, l)};
         exp_exception[l*EW +: EW] = 5'(k + l);
      end
   endtask

   task automatic fill_act(int k);
      for (int l = 0; l < LANES; l++) begin
         act_ieee[l*IW +: IW]      = ieee_val(k, l);
         act_recoded[l*RW +: RW]   = {1'b1, ieee_val(k, l)};
         act_exception[l*EW +: EW] = 5'(k + l);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_valid = 1'b0; exp_last = 1'b0; act_valid = 1'b0;
      fill_exp(0);
      fill_act(0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (test_count !== 32'd0) begin errors++; $display("FAIL rst_test_count got %0d want 0", test_count); end
      checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL rst_error_count got %0d want 0", error_count); end
      checks++; if ({fail_valid, orphan, progress, done, abort} !== 5'b00000) begin
         errors++; $display("FAIL rst_flags got %b want 00000", {fail_valid, orphan, progress, done, abort}); end
      checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL rst_exp_ready got %b want 1", exp_ready); end
   endtask

   // Five matching beats through a 3-cycle DUT, last on beat 5
   task automatic test_latency();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         exp_valid = (c < 5);
         exp_last  = (c == 4);
         if (c < 5) fill_exp(c);
         act_valid = (c >= 3);
         if (c >= 3) fill_act(c - 3);
         if (c < 5) begin
            checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL lat_ready cycle %0d got %b want 1", c, exp_ready); end
         end
         tick();
         if (c == 6) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_early got %b want 0", done); end
         end
      end
      exp_valid = 1'b0; exp_last = 1'b0; act_valid = 1'b0;
      checks++; if (test_count !== 32'd5) begin errors++; $display("FAIL lat_test_count got %0d want 5", test_count); end
      checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL lat_error_count got %0d want 0", error_count); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL lat_done got %b want 1", done); end
      checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_after_done got %b want 0", exp_ready); end
   endtask

   // Third beat (index 2) has a lane 1 IEEE mismatch
   task automatic test_mismatch();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         exp_valid = 1'b1;
         fill_exp(c);
         if (c == 2) exp_ieee[IW +: IW] = 64'h3FF0_0000_0000_0000;
         tick();
      end
      exp_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         act_valid = 1'b1;
         fill_act(c);
         if (c == 2) act_ieee[IW +: IW] = 64'h4000_0000_0000_0000;
         tick();
         if (c == 0) begin
            checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL mis_no_fail got %b want 0", fail_valid); end
         end
         if (c == 2) begin
            checks++; if (fail_valid !== 1'b1) begin errors++; $display("FAIL mis_fail_valid got %b want 1", fail_valid); end
            checks++; if (fail_lane_mask !== 2'b10) begin errors++; $display("FAIL mis_mask got %b want 10", fail_lane_mask); end
            checks++; if (fail_index !== 32'd2) begin errors++; $display("FAIL mis_index got %0d want 2", fail_index); end
            checks++; if (error_count !== 32'd1) begin errors++; $display("FAIL mis_error_count got %0d want 1", error_count); end
         end
      end
      act_valid = 1'b0;
      checks++; if (test_count !== 32'd4) begin errors++; $display("FAIL mis_test_count got %0d want 4", test_count); end
      checks++; if (error_count !== 32'd1) begin errors++; $display("FAIL mis_error_final got %0d want 1", error_count); end
   endtask

   // Every beat mismatches; abort after the third
   task automatic test_abort();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         exp_valid = 1'b1;
         fill_exp(c);
         tick();
      end
      exp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         act_valid = 1'b1;
         fill_act(c);
         act_ieee[IW-1:0] = ~act_ieee[IW-1:0];
         tick();
         checks++; if (error_count !== 32'(c + 1)) begin errors++; $display("FAIL abt_error_count beat %0d got %0d want %0d", c, error_count, c + 1); end
         checks++; if (abort !== (c == 2)) begin errors++; $display("FAIL abt_abort beat %0d got %b want %b", c, abort, (c == 2)); end
      end
      checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL abt_ready got %b want 0", exp_ready); end
      fill_act(3);
      act_ieee[IW-1:0] = ~act_ieee[IW-1:0];
      repeat (2) tick();
      act_valid = 1'b0;
      checks++; if (error_count !== 32'd3) begin errors++; $display("FAIL abt_error_frozen got %0d want 3", error_count); end
      checks++; if (test_count !== 32'd3) begin errors++; $display("FAIL abt_test_frozen got %0d want 3", test_count); end
      checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL abt_fail_valid got %b want 0", fail_valid); end
   endtask

   // Result with empty FIFO coinciding with a push: orphan, and the push is kept
   task automatic test_orphan();
      do_reset();
      tick();
      exp_valid = 1'b1; fill_exp(0);
      act_valid = 1'b1; fill_act(0);
      tick();
      exp_valid = 1'b0;
      checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orp_flag got %b want 1", orphan); end
      checks++; if (error_count !== 32'd1) begin errors++; $display("FAIL orp_error_count got %0d want 1", error_count); end
      checks++; if (test_count !== 32'd0) begin errors++; $display("FAIL orp_test_count got %0d want 0", test_count); end
      checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL orp_fail_valid got %b want 0", fail_valid); end
      tick();
      act_valid = 1'b0;
      checks++; if (test_count !== 32'd1) begin errors++; $display("FAIL orp_kept_entry got %0d want 1", test_count); end
      checks++; if (error_count !== 32'd1) begin errors++; $display("FAIL orp_error_after got %0d want 1", error_count); end
   endtask

   // Continuous source, stalled DUT: ready drops at 4 entries
   task automatic test_full();
      do_reset();
      exp_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         fill_exp(c);
         checks++; if (exp_ready !== (c < 4)) begin errors++; $display("FAIL full_ready cycle %0d got %b want %b", c, exp_ready, (c < 4)); end
         tick();
      end
      act_valid = 1'b1; fill_act(0);
      checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop got %b want 0", exp_ready); end
      tick();
      exp_valid = 1'b0;
      checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got %b want 1", exp_ready); end
      for (int c = 1; c < 5; c++) begin
         fill_act(c);
         tick();
      end
      act_valid = 1'b0;
      checks++; if (test_count !== 32'd4) begin errors++; $display("FAIL full_test_count got %0d want 4", test_count); end
      checks++; if (error_count !== 32'd1) begin errors++; $display("FAIL full_error_count got %0d want 1", error_count); end
      checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL full_orphan got %b want 1", orphan); end
   endtask

   // Nine matching beats, progress after tests 4 and 8 only
   task automatic test_progress();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         exp_valid = (c < 9);
         if (c < 9) fill_exp(c);
         act_valid = (c >= 1);
         if (c >= 1) fill_act(c - 1);
         tick();
         checks++; if (progress !== ((c == 4) || (c == 8))) begin
            errors++; $display("FAIL prog_pulse cycle %0d got %b want %b", c, progress, ((c == 4) || (c == 8))); end
      end
      exp_valid = 1'b0; act_valid = 1'b0;
      tick();
      checks++; if (progress !== 1'b0) begin errors++; $display("FAIL prog_idle got %b want 0", progress); end
      checks++; if (test_count !== 32'd9) begin errors++; $display("FAIL prog_test_count got %0d want 9", test_count); end
   endtask

   // Only the recoded field differs on lane 0
   task automatic test_recoded();
      logic want;
`ifdef HARDFLOAT_CHECK_RECODED_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      do_reset();
      exp_valid = 1'b1; fill_exp(7);
      tick();
      exp_valid = 1'b0;
      act_valid = 1'b1; fill_act(7);
      act_recoded[0] = ~act_recoded[0];
      tick();
      act_valid = 1'b0;
      checks++; if (fail_valid !== want) begin errors++; $display("FAIL rec_fail_valid got %b want %b", fail_valid, want); end
      checks++; if (error_count !== 32'(want)) begin errors++; $display("FAIL rec_error_count got %0d want %0d", error_count, want); end
      checks++; if (test_count !== 32'd1) begin errors++; $display("FAIL rec_test_count got %0d want 1", test_count); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_mismatch();
      test_abort();
      test_orphan();
      test_full();
      test_progress();
      test_recoded();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
